// File: rtl/centroid_sched.sv
// centroid_sched: round-robin time-multiplexer for the centroid unit.
// Define CENTROID_SCHED_IIR_EN to average each passing capture with the held lock.
module centroid_sched #(
    parameter int NUM_CH      = 4,
    parameter int DWELL       = 2,
    parameter int MIN_PIX     = 30,
    parameter int LOST_FRAMES = 3,
    parameter int H_LAST      = 639,
    parameter int V_LAST      = 479
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [11:0]           Hcnt,
    input  logic [11:0]           Vcnt,
    input  logic [NUM_CH-1:0]     mask_in,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [4*NUM_CH-1:0]   ch_weight,
    input  logic [11:0]           center_h_in,
    input  logic [11:0]           center_v_in,
    output logic                  din_sel,
    output logic [3:0]            weight_out,
    output logic [2:0]            cur_ch,
    output logic [12*NUM_CH-1:0]  ch_center_h,
    output logic [12*NUM_CH-1:0]  ch_center_v,
    output logic [NUM_CH-1:0]     ch_valid,
    output logic                  result_stb
);

    typedef enum logic [1:0] {IDLE, RUN, CAP} state_t;

    state_t              state, state_n;
    logic [2:0]          cur_n, last_ch, last_n, base, nxt_ch;
    logic [3:0]          dwell, dwell_n;
    logic [NUM_CH-1:0]   en_q, en_sel, valid_q;
    logic [20:0]         pix_cnt;
    logic                pass, fe, in_win, en_cur, nxt_ok;
    logic [11:0]         ctr_h [NUM_CH];
    logic [11:0]         ctr_v [NUM_CH];
    logic [3:0]          miss  [NUM_CH];

    assign fe = (Hcnt == 12'(H_LAST)) && (Vcnt == 12'(V_LAST));
    assign in_win = (Hcnt != 12'd0) && (Hcnt < 12'(H_LAST)) &&
                    (Vcnt != 12'd0) && (Vcnt < 12'(V_LAST));
    assign result_stb = (state == CAP);
    assign ch_valid = valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign ch_center_h[12*g +: 12] = ctr_h[g];
        assign ch_center_v[12*g +: 12] = ctr_v[g];
    end

    always_comb begin
        din_sel    = 1'b0;
        weight_out = 4'd0;
        en_cur     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch == 3'(i)) begin
                din_sel    = mask_in[i] & (state != IDLE);
                weight_out = (state != IDLE) ? ch_weight[4*i +: 4] : 4'd0;
                en_cur     = ch_enable[i];
            end
        end
    end

    // In CAP the enables latched at the preceding frame end are used,
    // so mid-frame enable edits never steer the scheduler.
    always_comb begin
        en_sel = (state == CAP) ? en_q : ch_enable;
        base   = (state == IDLE) ? last_ch : cur_ch;
        nxt_ok = 1'b0;
        nxt_ch = base;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (en_sel[(int'(base) + k) % NUM_CH]) begin
                nxt_ok = 1'b1;
                nxt_ch = 3'((int'(base) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur_ch;
        dwell_n = dwell;
        last_n  = last_ch;
        unique case (state)
            IDLE: begin
                if (fe && nxt_ok) begin
                    state_n = RUN;
                    cur_n   = nxt_ch;
                    dwell_n = 4'd0;
                end
            end
            RUN: begin
                if (fe) begin
                    if (!en_cur) begin
                        state_n = nxt_ok ? RUN : IDLE;
                        cur_n   = nxt_ch;
                        dwell_n = 4'd0;
                    end else if (dwell == 4'(DWELL - 1)) begin
                        state_n = CAP;
                    end else begin
                        dwell_n = dwell + 4'd1;
                    end
                end
            end
            CAP: begin
                last_n  = cur_ch;
                state_n = nxt_ok ? RUN : IDLE;
                cur_n   = nxt_ch;
                dwell_n = 4'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= IDLE;
            cur_ch  <= 3'd0;
            last_ch <= 3'(NUM_CH - 1);
            dwell   <= 4'd0;
        end else begin
            state   <= state_n;
            cur_ch  <= cur_n;
            last_ch <= last_n;
            dwell   <= dwell_n;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pix_cnt <= 21'd0;
            pass    <= 1'b0;
            en_q    <= '0;
        end else if (fe) begin
            pass    <= (pix_cnt > 21'(MIN_PIX));
            pix_cnt <= 21'd0;
            en_q    <= ch_enable;
        end else if (in_win && din_sel && (pix_cnt != '1)) begin
            pix_cnt <= pix_cnt + 21'd1;
        end
    end

`ifdef CENTROID_SCHED_IIR_EN
    function automatic logic [11:0] avg(input logic [11:0] a,
                                        input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12:1];
    endfunction
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ctr_h[i] <= 12'd320;
                ctr_v[i] <= 12'd240;
                miss[i]  <= 4'd0;
            end
        end else if (state == CAP) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cur_ch == 3'(i)) begin
                    if (pass) begin
`ifdef CENTROID_SCHED_IIR_EN
                        ctr_h[i] <= valid_q[i] ? avg(ctr_h[i], center_h_in) : center_h_in;
                        ctr_v[i] <= valid_q[i] ? avg(ctr_v[i], center_v_in) : center_v_in;
`else
                        ctr_h[i] <= center_h_in;
                        ctr_v[i] <= center_v_in;
`endif
                        valid_q[i] <= 1'b1;
                        miss[i]    <= 4'd0;
                    end else begin
                        if (miss[i] != 4'(LOST_FRAMES))
                            miss[i] <= miss[i] + 4'd1;
                        if (miss[i] >= 4'(LOST_FRAMES - 1))
                            valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
